// File: rtl/rtds_tx_framer.sv
// Transmit framer: double-buffered sample banks streamed as one AXI-Stream packet per trigger.
// Optional build macro TX_DELAY_EN adds cfg_delay and a DELAY state ahead of the first beat.
module rtds_tx_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    s_aclk,
    input  logic                    s_aresetn,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_commit,
    input  logic [ADDR_WIDTH:0]     cfg_len,
`ifdef TX_DELAY_EN
    input  logic [15:0]             cfg_delay,
`endif
    input  logic                    trigger,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    overrun,
    output logic [31:0]             frame_count
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef TX_DELAY_EN
    typedef enum logic [1:0] {IDLE, SEND, DELAY} state_t;
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif

    state_t                  state_reg;
    logic                    rd_bank_reg;
    logic                    commit_pending_reg;
    logic [ADDR_WIDTH:0]     len_reg;
    logic [ADDR_WIDTH:0]     idx_reg;
`ifdef TX_DELAY_EN
    logic [15:0]             delay_reg;
`endif

    // Bank select is the MSB of the address: bank rd_bank_reg is read, the other is written.
    logic [DATA_WIDTH-1:0]   mem [0:(2**(ADDR_WIDTH+1))-1];

    logic [ADDR_WIDTH:0]     len_sel;
    logic                    accept;
    logic                    next_bank;
    logic [ADDR_WIDTH:0]     rd_addr;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign len_sel   = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    assign accept    = trigger && (state_reg == IDLE) && (len_sel != '0);
    assign next_bank = rd_bank_reg ^ (commit_pending_reg | wr_commit);
    assign rd_addr   = (state_reg == IDLE) ? {next_bank, {ADDR_WIDTH{1'b0}}}
                                           : {rd_bank_reg, idx_reg[ADDR_WIDTH-1:0]};
    assign rd_word   = mem[rd_addr];

    assign m_axis_tkeep = '1;
    assign busy         = (state_reg != IDLE);

    always_ff @(posedge s_aclk) begin
        if (wr_en)
            mem[{~rd_bank_reg, wr_addr}] <= wr_data;
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_reg          <= IDLE;
            rd_bank_reg        <= 1'b0;
            commit_pending_reg <= 1'b0;
            len_reg            <= '0;
            idx_reg            <= '0;
`ifdef TX_DELAY_EN
            delay_reg          <= '0;
`endif
            m_axis_tdata       <= '0;
            m_axis_tlast       <= 1'b0;
            m_axis_tvalid      <= 1'b0;
            overrun            <= 1'b0;
            frame_count        <= '0;
        end else begin
            if (trigger && (state_reg != IDLE))
                overrun <= 1'b1;
            if (wr_commit)
                commit_pending_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // The swap absorbs a commit arriving in this same cycle.
                        rd_bank_reg        <= next_bank;
                        commit_pending_reg <= 1'b0;
                        len_reg            <= len_sel;
`ifdef TX_DELAY_EN
                        if (cfg_delay != 16'd0) begin
                            delay_reg <= cfg_delay;
                            idx_reg   <= '0;
                            state_reg <= DELAY;
                        end else begin
                            m_axis_tdata  <= rd_word;
                            m_axis_tlast  <= (len_sel == ONE);
                            m_axis_tvalid <= 1'b1;
                            idx_reg       <= ONE;
                            state_reg     <= SEND;
                        end
`else
                        m_axis_tdata  <= rd_word;
                        m_axis_tlast  <= (len_sel == ONE);
                        m_axis_tvalid <= 1'b1;
                        idx_reg       <= ONE;
                        state_reg     <= SEND;
`endif
                    end
                end
`ifdef TX_DELAY_EN
                DELAY: begin
                    if (delay_reg == 16'd1) begin
                        m_axis_tdata  <= rd_word;
                        m_axis_tlast  <= (len_reg == ONE);
                        m_axis_tvalid <= 1'b1;
                        idx_reg       <= ONE;
                        state_reg     <= SEND;
                    end else begin
                        delay_reg <= delay_reg - 16'd1;
                    end
                end
`endif
                SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            frame_count   <= frame_count + 32'd1;
                            state_reg     <= IDLE;
                        end else begin
                            m_axis_tdata <= rd_word;
                            m_axis_tlast <= ((idx_reg + ONE) == len_reg);
                            idx_reg      <= idx_reg + ONE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtds_tx_framer.sv
// Directed bench for rtds_tx_framer: a bank model feeds a beat scoreboard checked on each handshake.
module tb_rtds_tx_framer;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          s_aclk = 1'b0;
    logic          s_aresetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_commit = 1'b0;
    logic [AW:0]   cfg_len = '0;
`ifdef TX_DELAY_EN
    logic [15:0]   cfg_delay = '0;
`endif
    logic          trigger = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          busy;
    logic          overrun;
    logic [31:0]   frame_count;

    rtds_tx_framer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .s_aclk        (s_aclk),
        .s_aresetn     (s_aresetn),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_commit     (wr_commit),
        .cfg_len       (cfg_len),
`ifdef TX_DELAY_EN
        .cfg_delay     (cfg_delay),
`endif
        .trigger       (trigger),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .overrun       (overrun),
        .frame_count   (frame_count)
    );

    always #5 s_aclk = ~s_aclk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       sb_q[$];
    logic [31:0] mdl_mem [0:127];
    logic        mdl_rd = 1'b0;
    logic        mdl_pend = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge s_aclk);
    endtask

    task automatic host_write(input int addr, input logic [31:0] data);
        logic [6:0] a;
        a = {~mdl_rd, 6'(addr)};
        wr_en   = 1'b1;
        wr_addr = 6'(addr);
        wr_data = data;
        mdl_mem[a] = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic host_commit();
        wr_commit = 1'b1;
        mdl_pend  = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    // Drive one trigger; the model swaps banks and queues the frame exactly as the host expects.
    task automatic fire(input int len);
        int eff;
        beat_t b;
        logic [6:0] a;
        eff = (len > 64) ? 64 : len;
        cfg_len = 7'(len);
        trigger = 1'b1;
        if (eff != 0) begin
            if (mdl_pend) begin
                mdl_rd   = ~mdl_rd;
                mdl_pend = 1'b0;
            end
            for (int i = 0; i < eff; i++) begin
                a   = {mdl_rd, 6'(i)};
                b.d = mdl_mem[a];
                b.l = (i == eff - 1);
                sb_q.push_back(b);
            end
        end
        tick();
        trigger = 1'b0;
    endtask

    // mode 0: tready high; 1: tready 1,0,0 pattern; 2: pattern plus bank writes/commit;
    // 3: tready high plus triggers while busy and on the final beat.
    task automatic drain(input int mode, input int max_cyc);
        logic        stall = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        logic        done = 1'b0;
        logic        beat;
        logic        is_last;
        logic [6:0]  a;
        beat_t       b;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            m_axis_tready = (mode == 1 || mode == 2) ? (cyc % 3 == 0) : 1'b1;
            if (cyc == 0) begin
                check1("first_valid", m_axis_tvalid, 1'b1);
                check1("busy_in_frame", busy, 1'b1);
            end
            if (stall) begin
                check("hold_data", m_axis_tdata, pd);
                check1("hold_last", m_axis_tlast, pl);
                check1("hold_valid", m_axis_tvalid, 1'b1);
            end
            if (mode == 0 && sb_q.size() != 0)
                check1("valid_cont", m_axis_tvalid, 1'b1);
            beat    = m_axis_tvalid && m_axis_tready;
            is_last = 1'b0;
            if (beat) begin
                if (sb_q.size() == 0) begin
                    check("extra_beat", 32'(sb_q.size()), 32'd1);
                end else begin
                    b = sb_q.pop_front();
                    $display("beat data=%h last=%b exp_data=%h exp_last=%b",
                             m_axis_tdata, m_axis_tlast, b.d, b.l);
                    check("tdata", m_axis_tdata, b.d);
                    check1("tlast", m_axis_tlast, b.l);
                    is_last = (sb_q.size() == 0);
                end
            end
            stall = m_axis_tvalid && !m_axis_tready;
            pd    = m_axis_tdata;
            pl    = m_axis_tlast;
            if (mode == 2 && cyc < 4) begin
                a = {~mdl_rd, 6'(cyc)};
                wr_en   = 1'b1;
                wr_addr = 6'(cyc);
                wr_data = 32'hB0 + 32'(cyc);
                mdl_mem[a] = wr_data;
            end
            if (mode == 2 && cyc == 4) begin
                wr_commit = 1'b1;
                mdl_pend  = 1'b1;
            end
            if (mode == 3 && (cyc == 1 || is_last))
                trigger = 1'b1;
            tick();
            wr_en     = 1'b0;
            wr_commit = 1'b0;
            trigger   = 1'b0;
            if (is_last) begin
                exp_count++;
                check1("tvalid_after_last", m_axis_tvalid, 1'b0);
                check1("busy_after_last", busy, 1'b0);
                check("frame_count", frame_count, 32'(exp_count));
                done = 1'b1;
            end
        end
        check1("drain_done", done, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check1("rst_tvalid", m_axis_tvalid, 1'b0);
        check1("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        check("rst_tkeep", 32'(m_axis_tkeep), 32'hF);
        check1("rst_busy", busy, 1'b0);
        check1("rst_overrun", overrun, 1'b0);
        check("rst_frame_count", frame_count, 32'h0);
        s_aresetn = 1'b1;
        tick();

        // Basic frame 0xA0..0xA3, then the same frame with back-pressure
        for (int i = 0; i < 4; i++) host_write(i, 32'hA0 + 32'(i));
        host_commit();
        fire(4);
        drain(0, 20);
        fire(4);
        drain(1, 40);

        // Writes and commit during a frame; next frame swaps, the one after re-sends
        fire(4);
        drain(2, 40);
        fire(4);
        drain(0, 20);
        fire(4);
        drain(0, 20);

        // Triggers while busy and on the final beat are dropped and set overrun
        check1("overrun_pre", overrun, 1'b0);
        fire(4);
        drain(3, 20);
        check1("overrun_set", overrun, 1'b1);

        // Zero length is ignored; oversize length clamps to 64
        for (int i = 0; i < 64; i++) host_write(i, 32'hC00 + 32'(i));
        host_commit();
        fire(0);
        check1("len0_tvalid", m_axis_tvalid, 1'b0);
        check1("len0_busy", busy, 1'b0);
        tick();
        check1("len0_tvalid2", m_axis_tvalid, 1'b0);
        check("len0_count", frame_count, 32'(exp_count));
        fire(100);
        drain(0, 200);

        // Reset at beat 2, with a commit left pending that reset must discard
        fire(4);
        m_axis_tready = 1'b1;
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        tick();
        check("beat2_data", m_axis_tdata, 32'hC02);
        s_aresetn = 1'b0;
        #1;
        check1("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        check1("mid_rst_tlast", m_axis_tlast, 1'b0);
        check("mid_rst_tdata", m_axis_tdata, 32'h0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_count", frame_count, 32'h0);
        sb_q.delete();
        mdl_rd    = 1'b0;
        mdl_pend  = 1'b0;
        exp_count = 0;
        tick();
        s_aresetn = 1'b1;
        tick();
        fire(4);
        drain(0, 20);

`ifdef TX_DELAY_EN
        cfg_delay = 16'd10;
        fire(4);
        for (int k = 0; k < 10; k++) begin
            check1("delay_tvalid", m_axis_tvalid, 1'b0);
            check1("delay_busy", busy, 1'b1);
            tick();
        end
        drain(0, 20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
